keypad_scan_ctrl: RTL and testbench

Controller that sequences the 4x4 keypad row scanner and turns its raw row/column view into clean key events. It generates the scanner's advance tick and key_pressed input, and synchronizes and debounces the column lines. It emits exactly one hex key code per press over a valid/ready handshake and keeps the two most recent accepted digits for the seven-segment display path.

---
 rtl/keypad_scan_ctrl.sv | 269 ++++++++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl
//
// Sequencer and event generator for a 4x4 row-scanned keypad. Produces the
// scanner's advance tick, synchronizes and debounces the active-low column
// lines, and hands out one hex key code per press on a valid/ready handshake.
// The two most recently accepted codes are kept for the seven-segment path.
//
// Optional build macro:
//   KEYPAD_CTRL_REPEAT_EN - when defined, a held key re-emits its code every
//                           REPEAT_TICKS ticks until it is released. When
//                           undefined, no repeat counter exists and each press
//                           yields exactly one event.
//
// Parameters:
//   SCAN_DIV       clk cycles per internal tick (>= 2)
//   DEBOUNCE_TICKS stable ticks needed to confirm a press and a release (>= 1)
//   REPEAT_TICKS   ticks held before/between auto-repeat events
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   columns      raw keypad columns, active-low, bit3 = column 1
//   row_sel      row currently driven by the scanner, one-hot, bit3 = row 1
//   scan_tick    one-cycle scanner advance pulse (only while idle)
//   key_pressed  synchronized "any column low" back to the scanner
//   key_valid    key event available
//   key_code     hex code of the event, stable while key_valid
//   key_ready    consumer accepts the event when high together with key_valid
//   digit_new    most recently accepted code
//   digit_old    previously accepted code
// -----------------------------------------------------------------------------
module keypad_scan_ctrl #(
   parameter int unsigned SCAN_DIV       = 48000,
   parameter int unsigned DEBOUNCE_TICKS = 20,
   parameter int unsigned REPEAT_TICKS   = 500
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] columns,
   input  logic [3:0] row_sel,
   output logic       scan_tick,
   output logic       key_pressed,
   output logic       key_valid,
   output logic [3:0] key_code,
   input  logic       key_ready,
   output logic [3:0] digit_new,
   output logic [3:0] digit_old
);

   localparam int unsigned TickW = $clog2(SCAN_DIV);
   localparam int unsigned DebW  = $clog2(DEBOUNCE_TICKS + 1);

   typedef enum logic [2:0] {
      StIdle,
      StDebounce,
      StEmit,
      StHeld,
      StRelease
   } state_e;

   // --------------------------------------------------------------------------
   // Column synchronizer
   // --------------------------------------------------------------------------
   logic [3:0] col_meta_q;
   logic [3:0] col_sync_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_meta_q <= 4'hF;
         col_sync_q <= 4'hF;
      end else begin
         col_meta_q <= columns;
         col_sync_q <= col_meta_q;
      end
   end

   assign key_pressed = (col_sync_q != 4'hF);

   // --------------------------------------------------------------------------
   // Free-running tick divider
   // --------------------------------------------------------------------------
   logic [TickW-1:0] tick_cnt_q;
   logic             tick;

   assign tick = (tick_cnt_q == TickW'(SCAN_DIV - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_cnt_q <= '0;
      end else if (tick) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_q + 1'b1;
      end
   end

   // --------------------------------------------------------------------------
   // Snapshot and decode
   // --------------------------------------------------------------------------
   logic [7:0] snap;
   logic       snap_valid;

   assign snap       = {row_sel, col_sync_q};
   // Exactly one driven row and exactly one low column; ghosting and
   // multi-key combinations are rejected here.
   assign snap_valid = $onehot(row_sel) && $onehot(~col_sync_q);

   function automatic logic [3:0] decode(input logic [7:0] s);
      logic [3:0] code;
      code = 4'h0;
      unique case (s)
         8'b1000_0111: code = 4'h1;
         8'b1000_1011: code = 4'h2;
         8'b1000_1101: code = 4'h3;
         8'b1000_1110: code = 4'hA;
         8'b0100_0111: code = 4'h4;
         8'b0100_1011: code = 4'h5;
         8'b0100_1101: code = 4'h6;
         8'b0100_1110: code = 4'hB;
         8'b0010_0111: code = 4'h7;
         8'b0010_1011: code = 4'h8;
         8'b0010_1101: code = 4'h9;
         8'b0010_1110: code = 4'hC;
         8'b0001_0111: code = 4'hE;
         8'b0001_1011: code = 4'h0;
         8'b0001_1101: code = 4'hF;
         8'b0001_1110: code = 4'hD;
         default:      code = 4'h0;
      endcase
      return code;
   endfunction

   // --------------------------------------------------------------------------
   // Control FSM
   // --------------------------------------------------------------------------
   state_e          state_q;
   logic [7:0]      latch_q;
   logic [DebW-1:0] deb_cnt_q;
   logic            key_valid_q;
   logic [3:0]      key_code_q;
   logic [3:0]      digit_new_q;
   logic [3:0]      digit_old_q;

`ifdef KEYPAD_CTRL_REPEAT_EN
   localparam int unsigned RepW = $clog2(REPEAT_TICKS + 1);
   logic [RepW-1:0] rep_cnt_q;
`else
   logic unused_repeat;
   assign unused_repeat = ^REPEAT_TICKS;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         latch_q     <= '0;
         deb_cnt_q   <= '0;
         key_valid_q <= 1'b0;
         key_code_q  <= 4'h0;
         digit_new_q <= 4'h0;
         digit_old_q <= 4'h0;
`ifdef KEYPAD_CTRL_REPEAT_EN
         rep_cnt_q   <= '0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (tick && snap_valid) begin
                  latch_q <= snap;
                  if (DEBOUNCE_TICKS <= 1) begin
                     key_code_q  <= decode(snap);
                     key_valid_q <= 1'b1;
                     state_q     <= StEmit;
                  end else begin
                     deb_cnt_q <= DebW'(1);
                     state_q   <= StDebounce;
                  end
               end
            end

            StDebounce: begin
               if (tick) begin
                  // latch_q is always a valid snapshot, so equality implies validity
                  if (snap == latch_q) begin
                     if (deb_cnt_q == DebW'(DEBOUNCE_TICKS - 1)) begin
                        key_code_q  <= decode(latch_q);
                        key_valid_q <= 1'b1;
                        state_q     <= StEmit;
                     end else begin
                        deb_cnt_q <= deb_cnt_q + 1'b1;
                     end
                  end else begin
                     state_q <= StIdle;
                  end
               end
            end

            // Not gated by tick: the consumer may accept on any cycle and may
            // stall indefinitely without the event being lost or replaced.
            StEmit: begin
               if (key_ready) begin
                  key_valid_q <= 1'b0;
                  digit_old_q <= digit_new_q;
                  digit_new_q <= key_code_q;
                  state_q     <= StHeld;
`ifdef KEYPAD_CTRL_REPEAT_EN
                  rep_cnt_q   <= '0;
`endif
               end
            end

            StHeld: begin
               if (tick) begin
                  if (col_sync_q == 4'hF) begin
                     if (DEBOUNCE_TICKS <= 1) begin
                        state_q <= StIdle;
                     end else begin
                        deb_cnt_q <= DebW'(1);
                        state_q   <= StRelease;
                     end
                  end
`ifdef KEYPAD_CTRL_REPEAT_EN
                  else if (snap == latch_q) begin
                     if (rep_cnt_q == RepW'(REPEAT_TICKS - 1)) begin
                        rep_cnt_q   <= '0;
                        key_valid_q <= 1'b1;
                        state_q     <= StEmit;
                     end else begin
                        rep_cnt_q <= rep_cnt_q + 1'b1;
                     end
                  end else begin
                     // Some other column pattern: ignore it but restart the
                     // repeat interval so only a steady hold repeats.
                     rep_cnt_q <= '0;
                  end
`endif
               end
            end

            StRelease: begin
               if (tick) begin
                  if (col_sync_q == 4'hF) begin
                     if (deb_cnt_q == DebW'(DEBOUNCE_TICKS - 1)) begin
                        state_q <= StIdle;
                     end else begin
                        deb_cnt_q <= deb_cnt_q + 1'b1;
                     end
                  end else begin
                     state_q <= StHeld;
`ifdef KEYPAD_CTRL_REPEAT_EN
                     rep_cnt_q <= '0;
`endif
                  end
               end
            end

            default: state_q <= StIdle;
         endcase
      end
   end

   // The scanner only advances while no key activity is being tracked.
   assign scan_tick = tick && (state_q == StIdle);
   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;
   assign digit_new = digit_new_q;
   assign digit_old = digit_old_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan_ctrl
//
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4, DEBOUNCE_TICKS=3,
// REPEAT_TICKS=5. Stimulus pushes expected events into a queue; a monitor
// process pops and compares on every handshake, then checks the digit
// registers and the key_valid drop one cycle later.
// -----------------------------------------------------------------------------
module tb_keypad_scan_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] columns;
   logic [3:0] row_sel;
   logic       key_ready;
   logic       scan_tick;
   logic       key_pressed;
   logic       key_valid;
   logic [3:0] key_code;
   logic [3:0] digit_new;
   logic [3:0] digit_old;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   keypad_scan_ctrl #(
      .SCAN_DIV      (4),
      .DEBOUNCE_TICKS(3),
      .REPEAT_TICKS  (5)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .columns    (columns),
      .row_sel    (row_sel),
      .scan_tick  (scan_tick),
      .key_pressed(key_pressed),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .key_ready  (key_ready),
      .digit_new  (digit_new),
      .digit_old  (digit_old)
   );

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   typedef struct packed {
      logic [3:0] code;
      logic [3:0] dnew;
      logic [3:0] dold;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   bit   post_acc = 1'b0;
   int   cyc = 0;
   int   valid_cycles = 0;
   int   acc_cyc[$];
   logic [3:0] m_new = 4'h0;

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (reset !== 1'b1) begin
            post_acc = 1'b0;
         end else begin
            if (post_acc) begin
               chk("digit_new", int'(digit_new), int'(cur.dnew));
               chk("digit_old", int'(digit_old), int'(cur.dold));
               chk("valid_drop", int'(key_valid), 0);
               post_acc = 1'b0;
            end
            if (key_valid === 1'b1) valid_cycles++;
            if (key_valid === 1'b1 && key_ready === 1'b1) begin
               acc_cyc.push_back(cyc);
               if (exp_q.size() == 0) begin
                  chk("unexpected_event", 1, 0);
               end else begin
                  cur = exp_q.pop_front();
                  chk("key_code", int'(key_code), int'(cur.code));
                  post_acc = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_event(input logic [3:0] code);
      exp_t e;
      e.code = code;
      e.dnew = code;
      e.dold = m_new;
      exp_q.push_back(e);
      m_new = code;
   endtask

   task automatic wait_valid(input string name);
      bit found = 1'b0;
      for (int i = 0; i < 80 && !found; i++) begin
         step();
         if (key_valid === 1'b1) found = 1'b1;
      end
      chk({name, "_valid_seen"}, int'(found), 1);
   endtask

   task automatic wait_scan(input string name);
      bit found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         step();
         if (scan_tick === 1'b1) found = 1'b1;
      end
      chk({name, "_scan_resumed"}, int'(found), 1);
   endtask

   task automatic press_accept(input string name, input logic [3:0] r, input logic [3:0] c,
                               input logic [3:0] code);
      int v0;
      int st;
      expect_event(code);
      key_ready = 1'b1;
      v0        = valid_cycles;
      row_sel   = r;
      columns   = c;
      wait_valid(name);
      st = 0;
      repeat (12) begin
         step();
         if (scan_tick === 1'b1) st++;
      end
      chk({name, "_no_scan_held"}, st, 0);
      chk({name, "_key_pressed"}, int'(key_pressed), 1);
      chk({name, "_one_pulse"}, valid_cycles - v0, 1);
      columns = 4'hF;
      wait_scan(name);
   endtask

   task automatic count_scans(input string name, input int req);
      int n = 0;
      repeat (16) begin
         step();
         if (scan_tick === 1'b1) n++;
      end
      chk({name, "_scan_count"}, n, req);
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   int  pulse_at[$];
   int  v0;
   bit  stable;
   bit  done;
   int  n0;

   initial begin
      reset     = 1'b0;
      columns   = 4'hF;
      row_sel   = 4'b1000;
      key_ready = 1'b0;
      repeat (3) step();

      // Reset state
      chk("rst_key_valid", int'(key_valid), 0);
      chk("rst_digit_new", int'(digit_new), 0);
      chk("rst_digit_old", int'(digit_old), 0);
      chk("rst_scan_tick", int'(scan_tick), 0);
      chk("rst_key_pressed", int'(key_pressed), 0);
      chk("rst_key_code", int'(key_code), 0);

      // 1: idle scan cadence
      reset = 1'b1;
      stable = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         if (scan_tick === 1'b1) pulse_at.push_back(i);
         if (key_valid !== 1'b0) stable = 1'b0;
      end
      chk("idle_scan_count", pulse_at.size(), 4);
      for (int i = 1; i < pulse_at.size(); i++) chk("idle_scan_gap", pulse_at[i] - pulse_at[i-1], 4);
      chk("idle_no_valid", int'(stable), 1);

      // 2: row 1, column 2 -> '2'
      press_accept("key2", 4'b1000, 4'b1011, 4'h2);

      // 3: row 4, column 1 -> 'E'
      press_accept("keyE", 4'b0001, 4'b0111, 4'hE);

      // 4: one-tick glitch must not produce an event
      v0        = valid_cycles;
      row_sel   = 4'b1000;
      columns   = 4'b1110;
      repeat (4) step();
      columns   = 4'hF;
      repeat (40) step();
      chk("glitch_no_event", valid_cycles - v0, 0);
      count_scans("glitch", 4);

      // 5: consumer stall on '8'
      expect_event(4'h8);
      key_ready = 1'b0;
      row_sel   = 4'b0010;
      columns   = 4'b1011;
      wait_valid("stall");
      stable = 1'b1;
      repeat (50) begin
         step();
         if (key_valid !== 1'b1 || key_code !== 4'h8) stable = 1'b0;
      end
      chk("stall_stable", int'(stable), 1);
      chk("stall_pending", exp_q.size(), 1);
      key_ready = 1'b1;
      step();
      chk("stall_valid_drop", int'(key_valid), 0);
      chk("stall_popped", exp_q.size(), 0);
      columns = 4'hF;
      wait_scan("stall");

`ifdef KEYPAD_CTRL_REPEAT_EN
      // Auto-repeat: holding 'A' yields an event every 5 ticks (20 cycles)
      expect_event(4'hA);
      expect_event(4'hA);
      expect_event(4'hA);
      n0        = acc_cyc.size();
      key_ready = 1'b1;
      row_sel   = 4'b1000;
      columns   = 4'b1110;
      done      = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         step();
         if (acc_cyc.size() >= n0 + 3) done = 1'b1;
      end
      chk("repeat_three_events", int'(done), 1);
      if (done) begin
         chk("repeat_gap1", acc_cyc[n0+1] - acc_cyc[n0], 20);
         chk("repeat_gap2", acc_cyc[n0+2] - acc_cyc[n0+1], 20);
      end
      columns = 4'hF;
      wait_scan("repeat");
`endif

      // 6: reset while an event is pending
      key_ready = 1'b0;
      row_sel   = 4'b1000;
      columns   = 4'b1110;
      wait_valid("rst_emit");
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("midrst_key_valid", int'(key_valid), 0);
      chk("midrst_digit_new", int'(digit_new), 0);
      chk("midrst_digit_old", int'(digit_old), 0);
      m_new   = 4'h0;
      columns = 4'hF;
      repeat (3) step();
      reset = 1'b1;
      count_scans("post_rst", 4);

      // Row 2, column 2 -> '5' after reset, digits restart from 0
      press_accept("key5", 4'b0100, 4'b1011, 4'h5);
      repeat (4) step();
      chk("final_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
